uart_rx: RTL and testbench

Oversampling serial receiver that turns an 8N1 UART line into one-cycle byte strobes. It sits directly upstream of the bridge receiver and drives that block's `data_i`/`valid_i` pair with recovered bytes. The bridge always accepts, so the interface has no backpressure. It validates start and stop bits and reports framing errors separately from good data.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_rx_pkg;

    localparam int unsigned DataBits = 8;

    // Width of a counter that has to reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a chosen reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver: byte strobes on good frames, framing-error strobes otherwise.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_i,
    output logic [DataBits-1:0] data_o,
    output logic                valid_o,
    output logic                framing_error_o
);

    localparam int unsigned     Half    = CLOCKS_PER_BAUD / 2;
    localparam int unsigned     CntW    = cnt_width(CLOCKS_PER_BAUD);
    localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLOCKS_PER_BAUD - 1);
    localparam logic [2:0]      IdxLast = 3'(DataBits - 1);

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    // After reset the synchronizer shows its reset level, not the line; this
    // marks when two real line samples have reached rx_s.
    logic [1:0]          prime_q;
    logic                rx_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx_i),
        .q_o(rx_s)
    );

    // Next-state logic: sample at mid-start, then once per bit period after that.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            StWaitIdle: begin
                if (prime_q[1] && rx_s) state_d = StIdle;
            end
            StIdle: begin
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                bit_idx_d = '0;
                if (clk_cnt_q == CntHalf) state_d = rx_s ? StIdle : StData;
            end
            StData: begin
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == IdxLast) state_d = StStop;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StStop: begin
                if (clk_cnt_q == CntLast) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitIdle;
                    end
                end
            end
            default: state_d = StWaitIdle;
        endcase
        if (state_q == StIdle || state_q == StWaitIdle || state_d != state_q) clk_cnt_d = '0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            prime_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            prime_q   <= {prime_q[0], 1'b1};
        end
    end

    assign data_o          = data_q;
    assign valid_o         = valid_q;
    assign framing_error_o = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at N=8 and N=5: line history is replayed through a sample-point model.
module tb_uart_rx;

    localparam int MaxCyc = 12000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx8, rx5;
    logic [7:0] data8, data5;
    logic       valid8, valid5, ferr8, ferr5;

    always #5 clk = ~clk;

    uart_rx #(.CLOCKS_PER_BAUD(8)) dut8 (
        .clk(clk), .rst(rst), .rx_i(rx8),
        .data_o(data8), .valid_o(valid8), .framing_error_o(ferr8)
    );

    uart_rx #(.CLOCKS_PER_BAUD(5)) dut5 (
        .clk(clk), .rst(rst), .rx_i(rx5),
        .data_o(data5), .valid_o(valid5), .framing_error_o(ferr5)
    );

    // Edge index c: line_h/rst_h hold values seen at edge c, obs_h what outputs show after it.
    int         cyc = 0;
    logic       line_h [2][MaxCyc];
    logic       rst_h  [MaxCyc];
    logic [9:0] obs_h  [2][MaxCyc];
    logic [9:0] exp_h  [2][MaxCyc];
    logic [1:0] ev_k   [MaxCyc];
    logic [7:0] ev_d   [MaxCyc];
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) begin
        if (cyc < MaxCyc) begin
            line_h[0][cyc] = rx8;
            line_h[1][cyc] = rx5;
            rst_h[cyc]     = rst;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc > 0 && cyc <= MaxCyc) begin
            obs_h[0][cyc-1] = {valid8, ferr8, data8};
            obs_h[1][cyc-1] = {valid5, ferr5, data5};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int k, input logic v);
        if (k == 0) rx8 = v;
        else rx5 = v;
    endtask

    // One frame at exactly n cycles per bit; e is the first edge that samples the start bit.
    task automatic frame(input int k, input int n, input logic [7:0] b, input logic stop,
                         output int e);
        drive(k, 1'b0);
        e = cyc;
        tick(n);
        for (int i = 0; i < 8; i++) begin
            drive(k, b[i]);
            tick(n);
        end
        drive(k, stop);
        tick(n);
    endtask

    function automatic int first_rst(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (rst_h[i]) return i;
        return -1;
    endfunction

    function automatic int count_bit(input int k, input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (obs_h[k][i][b]) n++;
        return n;
    endfunction

    // Receiver behaviour in terms of sample points: the logic sees the line two edges late,
    // samples it at detect+HALF+k*N, and reports at the stop sample edge.
    task automatic run_model(input int k, input int n, input int ncyc);
        int         half, c, rel, end_c, hit;
        bit         need_idle;
        logic [7:0] b, held;
        for (int i = 0; i < ncyc; i++) begin
            ev_k[i] = 2'd0;
            ev_d[i] = 8'h00;
        end
        half = n / 2;
        c = 0;
        rel = 0;
        need_idle = 1'b1;
        while (c < ncyc) begin
            if (rst_h[c]) begin
                need_idle = 1'b1;
                rel = c + 1;
                c++;
            end else if (need_idle) begin
                if (c >= rel + 2 && line_h[k][c-2]) need_idle = 1'b0;
                c++;
            end else if (line_h[k][c-2]) begin
                c++;
            end else begin
                end_c = c + half + 9 * n;
                if (end_c >= ncyc) begin
                    c = ncyc;
                end else begin
                    hit = first_rst(c + 1, c + half);
                    if (hit >= 0) c = hit;
                    else if (line_h[k][c+half-2]) c = c + half + 1;
                    else begin
                        hit = first_rst(c + half + 1, end_c);
                        if (hit >= 0) c = hit;
                        else begin
                            for (int j = 0; j < 8; j++) b[j] = line_h[k][c+half+(j+1)*n-2];
                            if (line_h[k][end_c-2]) begin
                                ev_k[end_c] = 2'd1;
                                ev_d[end_c] = b;
                            end else begin
                                ev_k[end_c] = 2'd2;
                                need_idle = 1'b1;
                            end
                            c = end_c + 1;
                        end
                    end
                end
            end
        end
        held = 8'h00;
        for (int i = 0; i + 1 < ncyc; i++) begin
            if (rst_h[i]) held = 8'h00;
            if (ev_k[i] == 2'd1) held = ev_d[i];
            if (rst_h[i+1]) exp_h[k][i] = 10'h000;
            else exp_h[k][i] = {ev_k[i] == 2'd1, ev_k[i] == 2'd2, held};
        end
    endtask

    initial begin
        int         e, e2, w0, nc, r;
        logic [7:0] rb;
        rst = 1'b1;
        rx8 = 1'b1;
        rx5 = 1'b1;
        tick(3);
        check("reset_outputs", {22'd0, valid8, ferr8, data8}, 32'h0);
        rst = 1'b0;
        tick(10);

        // Single byte: strobe visible right after edge e+78, i.e. the cycle ending at e+79.
        frame(0, 8, 8'h52, 1'b1, e);
        tick(5);
        check("single_strobe", {22'd0, obs_h[0][e+78]}, {22'd0, 2'b10, 8'h52});
        check("single_before", {31'd0, obs_h[0][e+77][9]}, 32'd0);
        check("single_after", {31'd0, obs_h[0][e+79][9]}, 32'd0);

        // Back-to-back frames, no gap.
        frame(0, 8, 8'h57, 1'b1, e);
        frame(0, 8, 8'h31, 1'b1, e2);
        tick(5);
        check("b2b_spacing", e2 - e, 32'd80);
        check("b2b_first", {22'd0, obs_h[0][e+78]}, {22'd0, 2'b10, 8'h57});
        check("b2b_second", {22'd0, obs_h[0][e2+78]}, {22'd0, 2'b10, 8'h31});

        // Glitch shorter than half a bit.
        w0 = cyc;
        drive(0, 1'b0);
        tick(2);
        drive(0, 1'b1);
        tick(100);
        check("glitch_pulses", count_bit(0, 9, w0, cyc - 2) + count_bit(0, 8, w0, cyc - 2), 0);
        frame(0, 8, 8'hA5, 1'b1, e);
        drive(0, 1'b1);
        tick(5);
        check("after_glitch", {22'd0, obs_h[0][e+78]}, {22'd0, 2'b10, 8'hA5});

        // Break: zero byte with a low stop bit, then the line stays low.
        w0 = cyc;
        frame(0, 8, 8'h00, 1'b0, e);
        tick(50);
        check("break_ferr", count_bit(0, 8, w0, cyc - 2), 32'd1);
        check("break_valid", count_bit(0, 9, w0, cyc - 2), 32'd0);
        check("break_data", {24'd0, obs_h[0][cyc-2][7:0]}, 32'hA5);
        drive(0, 1'b1);
        tick(20);
        frame(0, 8, 8'h0D, 1'b1, e);
        drive(0, 1'b1);
        tick(10);
        check("after_break", {22'd0, obs_h[0][e+78]}, {22'd0, 2'b10, 8'h0D});

        // Reset in the middle of data bit 3, line low after release.
        rb = 8'h3C;
        drive(0, 1'b0);
        tick(8);
        for (int i = 0; i < 3; i++) begin
            drive(0, rb[i]);
            tick(8);
        end
        drive(0, rb[3]);
        tick(3);
        rst = 1'b1;
        #1;
        check("reset_midframe", {22'd0, valid8, ferr8, data8}, 32'h0);
        tick(2);
        drive(0, 1'b0);
        rst = 1'b0;
        w0 = cyc;
        tick(20);
        drive(0, 1'b1);
        tick(10);
        check("post_reset_quiet", count_bit(0, 9, w0, cyc - 2) + count_bit(0, 8, w0, cyc - 2), 0);
        frame(0, 8, 8'h41, 1'b1, e);
        drive(0, 1'b1);
        tick(10);
        check("after_reset", {22'd0, obs_h[0][e+78]}, {22'd0, 2'b10, 8'h41});

        // Random traffic at N=8: bytes, occasional bad stop bits and glitches, random gaps.
        for (int i = 0; i < 15; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive(0, 1'b0);
                tick($urandom_range(1, 3));
                drive(0, 1'b1);
                tick(20);
            end else begin
                rb = 8'($urandom_range(0, 255));
                frame(0, 8, rb, (r != 1), e);
                drive(0, 1'b1);
                tick($urandom_range(0, 12));
            end
        end
        tick(10);

        // Odd divisor N=5: strobe right after edge e+49 (cycle ending at e+50).
        frame(1, 5, 8'hFF, 1'b1, e);
        drive(1, 1'b1);
        tick(5);
        check("n5_strobe", {22'd0, obs_h[1][e+49]}, {22'd0, 2'b10, 8'hFF});
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            frame(1, 5, rb, 1'b1, e);
            drive(1, 1'b1);
            tick($urandom_range(0, 8));
        end
        tick(20);

        // Whole-run comparison against the model, every cycle, both instances.
        check("cycle_budget", {31'd0, cyc < MaxCyc - 2}, 32'd1);
        nc = (cyc < MaxCyc) ? cyc - 1 : MaxCyc;
        run_model(0, 8, nc);
        run_model(1, 5, nc);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c + 1 < nc; c++) begin
                check($sformatf("inst%0d_cyc%0d", k, c), {22'd0, obs_h[k][c]}, {22'd0, exp_h[k][c]});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
